// File: rtl/idma_rd_2d_cmd_gen.sv
// 2D read command generator: splits a line/stride descriptor into bursts of at most MAX_CHUNK words.
// Define IDMA_RD_CMD_GEN_PERF_EN to build the command/stall performance counters.
module idma_rd_2d_cmd_gen #(
  parameter int unsigned MAX_CHUNK  = 16,
  parameter int unsigned WORD_BYTES = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [31:0] cfg_base_addr,
  input  logic [15:0] cfg_line_words,
  input  logic [15:0] cfg_line_num,
  input  logic [31:0] cfg_line_stride,
  input  logic        rd_addr_ready,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [31:0] rd_num,
  output logic        busy,
  output logic        done,
  output logic [15:0] perf_cmd_cnt,
  output logic [15:0] perf_stall_cnt
);
  localparam logic [15:0] CHUNK = 16'(MAX_CHUNK);
  localparam logic [31:0] STEP  = 32'(MAX_CHUNK * WORD_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;
  state_t state, state_nxt;

  logic [31:0] line_base, cur_addr, stride_q;
  logic [15:0] rem, line_left, words_q;
  logic        start_ok, push, last_chunk, empty_desc;

  assign start_ok   = (state == IDLE) & cfg_start & ~cfg_abort;
  assign empty_desc = (cfg_line_words == 16'd0) | (cfg_line_num == 16'd0);
  assign push       = (state == ISSUE) & rd_addr_ready;
  assign last_chunk = (rem <= CHUNK);

  assign rd_addr = cur_addr;
  assign rd_num  = {16'd0, last_chunk ? rem : CHUNK};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = empty_desc ? FIN : ISSUE;
      end
      ISSUE: begin
        busy   = 1'b1;
        rd_req = rd_addr_ready;
        if (cfg_abort)                                     state_nxt = IDLE;
        else if (push && last_chunk && line_left == 16'd1) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      line_base <= '0;
      cur_addr  <= '0;
      stride_q  <= '0;
      rem       <= '0;
      line_left <= '0;
      words_q   <= '0;
    end else if (start_ok) begin
      line_base <= cfg_base_addr;
      cur_addr  <= cfg_base_addr;
      stride_q  <= cfg_line_stride;
      rem       <= cfg_line_words;
      line_left <= cfg_line_num;
      words_q   <= cfg_line_words;
    end else if (push) begin
      if (!last_chunk) begin
        rem      <= rem - CHUNK;
        cur_addr <= cur_addr + STEP;
      end else if (line_left > 16'd1) begin
        // next line starts a fixed stride from the previous line start, not from cur_addr
        line_base <= line_base + stride_q;
        cur_addr  <= line_base + stride_q;
        rem       <= words_q;
        line_left <= line_left - 16'd1;
      end
    end
  end

`ifdef IDMA_RD_CMD_GEN_PERF_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_cmd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else if (start_ok) begin
      perf_cmd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else if (state == ISSUE) begin
      if (rd_addr_ready && perf_cmd_cnt != 16'hFFFF)    perf_cmd_cnt   <= perf_cmd_cnt + 16'd1;
      if (!rd_addr_ready && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`else
  assign perf_cmd_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/idma_rd_2d_cmd_gen.md
IDMA_RD_2D_CMD_GEN -- requirements
Module: idma_rd_2d_cmd_gen

Interface
REQ-001 SHALL have parameter MAX_CHUNK, default 16: maximum words per issued command (1..16; matches 4-bit AXI len).
REQ-002 SHALL have parameter WORD_BYTES, default 32: byte size of one 256-bit word; used as the address step.
REQ-003 SHALL have port aclk, input, 1: clock.
REQ-004 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_start, input, 1: one-cycle pulse; latches the descriptor.
REQ-006 SHALL have port cfg_abort, input, 1: cancels the active descriptor.
REQ-007 SHALL have port cfg_base_addr, input, 32: byte address of line 0.
REQ-008 SHALL have port cfg_line_words, input, 16: words per line.
REQ-009 SHALL have port cfg_line_num, input, 16: number of lines.
REQ-010 SHALL have port cfg_line_stride, input, 32: byte distance between line starts.
REQ-011 SHALL have port rd_addr_ready, input, 1: downstream address FIFO not full.
REQ-012 SHALL have port rd_req, output, 1: command push strobe.
REQ-013 SHALL have port rd_addr, output, 32: command byte address.
REQ-014 SHALL have port rd_num, output, 32: command word count.
REQ-015 SHALL have port busy, output, 1: descriptor active.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after the last command is pushed.
REQ-017 SHALL have port perf_cmd_cnt, output, 16: commands pushed for the current descriptor.
REQ-018 SHALL have port perf_stall_cnt, output, 16: cycles spent in ISSUE with rd_addr_ready low.

Function
REQ-019 SHALL implement states IDLE, ISSUE and FIN.
REQ-020 SHALL, in IDLE on cfg_start with line_words!=0 and line_num!=0, latch the descriptor, set line_base=cur_addr=cfg_base_addr, rem=line_words, line_left=line_num, and go to ISSUE.
REQ-021 SHALL, on cfg_start with line_words==0 or line_num==0, go to FIN without issuing any rd_req.
REQ-022 SHALL ignore cfg_start while busy.
REQ-023 SHALL drive rd_req = (state==ISSUE) & rd_addr_ready combinationally, so that one command is pushed per handshake cycle and none is pushed when ready is low.
REQ-024 SHALL drive rd_addr=cur_addr and rd_num=zero-extended min(rem, MAX_CHUNK) from registers; both are stable while rd_req is withheld.
REQ-025 SHALL, on each push with rem>MAX_CHUNK, update rem-=MAX_CHUNK and cur_addr+=MAX_CHUNK*WORD_BYTES.
REQ-026 SHALL, on each push with rem<=MAX_CHUNK and line_left>1, update line_base+=stride, cur_addr=line_base+stride, rem=line_words and line_left-=1.
REQ-027 SHALL, on each push with rem<=MAX_CHUNK and line_left==1, go to FIN.
REQ-028 SHALL, in FIN, assert done for exactly one cycle and return to IDLE.
REQ-029 SHALL compute all address arithmetic modulo 2^32, with no 4K-boundary handling (handled downstream).
REQ-030 SHALL assert busy in ISSUE and FIN and deassert it in IDLE.
REQ-031 SHALL, on cfg_abort in ISSUE, go to IDLE next cycle with no done and no further rd_req; the abort-cycle rd_req still counts if the handshake occurs that cycle.
REQ-032 SHALL give cfg_abort priority over cfg_start in the same cycle.
REQ-033 SHALL clear the perf counters on an accepted cfg_start and saturate them at 16'hFFFF.

Reset
REQ-034 SHALL, on aresetn low, immediately force state=IDLE, rd_req=0, rd_addr=0, rd_num=0, busy=0, done=0 and both perf counters to 0.
REQ-035 SHALL, on reset asserted mid-descriptor, drop the descriptor with no done, and require a new cfg_start after release.

Configuration
REQ-036 SHALL, with macro IDMA_RD_CMD_GEN_PERF_EN defined, implement perf_cmd_cnt and perf_stall_cnt as specified.
REQ-037 SHALL, with IDMA_RD_CMD_GEN_PERF_EN undefined, tie both perf outputs to 0, instantiate no counter logic, and leave all other behaviour unchanged.

Verification
REQ-038 SHALL cover: base=0x1000, line_words=40, line_num=1, ready=1 -> pushes (0x1000,16),(0x1200,16),(0x1400,8) on consecutive cycles, then done pulse, perf_cmd_cnt=3.
REQ-039 SHALL cover: base=0x0, line_words=10, line_num=3, stride=0x800 -> pushes (0x0,10),(0x800,10),(0x1000,10), then done.
REQ-040 SHALL cover: ready low 5 cycles during ISSUE -> no rd_req, rd_addr/rd_num held, perf_stall_cnt=5.
REQ-041 SHALL cover: line_words=0 -> no rd_req, done one cycle after FIN entry, busy high for exactly 1 cycle.
REQ-042 SHALL cover: cfg_abort after 2nd push of a 5-command descriptor -> idle next cycle, no done, perf_cmd_cnt=2.
REQ-043 SHALL cover: base=0xFFFFFF00, line_words=16, line_num=2, stride=0x200 -> second push address 0x00000100 (wrap).
